// File: rtl/cnn_cell_mac.sv
// CNN cell multiply-accumulate: sum of A*Y + B*U over TAPS neighbourhood taps plus bias I.
// Optional output clamping is enabled by defining CNN_MAC_SAT_EN; the default build wraps.
//
// state  | meaning
// IDLE   | waiting for start, bias latched on accept
// ACCUM  | accepting taps until TAPS have been summed
// BIAS   | one cycle: add latched bias, register result
// OUT    | presenting result until out_ready

module cnn_cell_mac #(
    parameter int DATA_W = 8,
    parameter int Y_W    = 9,
    parameter int TAPS   = 9,
    parameter int OUT_W  = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     tap_valid,
    output logic                     tap_ready,
    input  logic signed [DATA_W-1:0] tap_a,
    input  logic signed [DATA_W-1:0] tap_b,
    input  logic signed [Y_W-1:0]    tap_y,
    input  logic        [DATA_W-1:0] tap_u,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     busy,
    output logic                     out_sat
);

    localparam int ACC_W = DATA_W + Y_W + 8;
    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int AY_W  = DATA_W + Y_W;
    localparam int BU_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_BIAS  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [ACC_W-1:0]  acc;
    logic        [CNT_W-1:0]  tap_cnt;
    logic signed [DATA_W-1:0] bias_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic                     out_sat_q;

    logic                     tap_fire;
    logic                     last_tap;
    logic signed [AY_W-1:0]   prod_ay;
    logic signed [DATA_W:0]   u_ext;
    logic signed [BU_W-1:0]   prod_bu;
    logic signed [ACC_W-1:0]  tap_sum;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_bias;
    logic signed [OUT_W-1:0]  res;
    logic                     res_sat;

    // U is a pixel magnitude: zero-extend so the B*U product stays signed x unsigned.
    assign u_ext    = {1'b0, tap_u};
    assign prod_ay  = tap_a * tap_y;
    assign prod_bu  = tap_b * u_ext;
    assign tap_sum  = {{(ACC_W-AY_W){prod_ay[AY_W-1]}}, prod_ay}
                    + {{(ACC_W-BU_W){prod_bu[BU_W-1]}}, prod_bu};
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
    assign acc_bias = acc + bias_ext;

    assign tap_ready = (state == S_ACCUM);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign tap_fire  = tap_valid && tap_ready;
    assign last_tap  = (tap_cnt == CNT_W'(TAPS - 1));
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    generate
        if (OUT_W < ACC_W) begin : g_narrow
`ifdef CNN_MAC_SAT_EN
            logic ovf;
            // Out of range when the bits above the OUT_W sign bit disagree with the MSB.
            assign ovf = (acc_bias[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc_bias[ACC_W-1]}});

            always_comb begin
                res_sat = ovf;
                res     = acc_bias[OUT_W-1:0];
                if (ovf) begin
                    if (acc_bias[ACC_W-1]) res = {1'b1, {(OUT_W-1){1'b0}}};
                    else                   res = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
`else
            logic unused_acc_hi;
            assign unused_acc_hi = ^acc_bias[ACC_W-1:OUT_W];
            assign res           = acc_bias[OUT_W-1:0];
            assign res_sat       = 1'b0;
`endif
        end else begin : g_wide
            assign res     = OUT_W'(acc_bias);
            assign res_sat = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ACCUM;
            S_ACCUM: if (tap_fire && last_tap) state_nx = S_BIAS;
            S_BIAS:  state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            tap_cnt    <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        tap_cnt <= '0;
                        bias_q  <= bias;
                    end
                end
                S_ACCUM: begin
                    if (tap_fire) begin
                        acc     <= acc + tap_sum;
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                S_BIAS: begin
                    acc        <= acc_bias;
                    out_data_q <= res;
                    out_sat_q  <= res_sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_cell_mac.sv
// Self-checking bench for cnn_cell_mac: directed cases plus randomized evaluations
// compared against an arithmetic reference (clamp or wrap chosen by CNN_MAC_SAT_EN).

module tb_cnn_cell_mac;

    localparam int DATA_W = 8;
    localparam int Y_W    = 9;
    localparam int TAPS   = 9;
    localparam int OUT_W  = 17;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic signed [DATA_W-1:0] bias;
    logic                     tap_valid;
    logic                     tap_ready;
    logic signed [DATA_W-1:0] tap_a;
    logic signed [DATA_W-1:0] tap_b;
    logic signed [Y_W-1:0]    tap_y;
    logic        [DATA_W-1:0] tap_u;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     busy;
    logic                     out_sat;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int ta [TAPS];
    int ty [TAPS];
    int tb [TAPS];
    int tu [TAPS];

    cnn_cell_mac #(
        .DATA_W(DATA_W), .Y_W(Y_W), .TAPS(TAPS), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .tap_valid(tap_valid), .tap_ready(tap_ready),
        .tap_a(tap_a), .tap_b(tap_b), .tap_y(tap_y), .tap_u(tap_u),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, then reduce to OUT_W signed.
    function automatic void model(input longint s, output longint d, output bit sat);
        longint hi, lo, r;
        hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo  = -(longint'(1) <<< (OUT_W - 1));
        sat = 1'b0;
`ifdef CNN_MAC_SAT_EN
        if (s > hi)      begin d = hi; sat = 1'b1; end
        else if (s < lo) begin d = lo; sat = 1'b1; end
        else             d = s;
`else
        r = s & ((longint'(1) <<< OUT_W) - 1);
        if (r > hi) r = r - (longint'(1) <<< OUT_W);
        d = r;
`endif
    endfunction

    task automatic fill_const(input int a, input int y, input int b, input int u);
        for (int i = 0; i < TAPS; i++) begin
            ta[i] = a; ty[i] = y; tb[i] = b; tu[i] = u;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < TAPS; i++) begin
            ta[i] = int'($urandom_range(0, 255)) - 128;
            ty[i] = int'($urandom_range(0, 511)) - 256;
            tb[i] = int'($urandom_range(0, 255)) - 128;
            tu[i] = int'($urandom_range(0, 255));
        end
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random valid
    task automatic feed_taps(input int mode, input int n, input bit poke);
        int  idx;
        int  guard;
        bit  rdy;
        idx   = 0;
        guard = 0;
        while (idx < n && guard < 500) begin
            tap_a = ta[idx][DATA_W-1:0];
            tap_y = ty[idx][Y_W-1:0];
            tap_b = tb[idx][DATA_W-1:0];
            tap_u = tu[idx][DATA_W-1:0];
            case (mode)
                0:       tap_valid = 1'b1;
                1:       tap_valid = (guard[0] == 1'b0);
                default: tap_valid = 1'($urandom_range(0, 1));
            endcase
            start = poke && (idx == 4);
            @(negedge clk);
            rdy = tap_ready;
            @(posedge clk);
            #1;
            if (tap_valid && rdy) idx++;
            guard++;
        end
        tap_valid = 1'b0;
        start     = 1'b0;
        check("taps_accepted", idx, n);
    endtask

    task automatic eval(input int bias_v, input int mode, input int stall,
                        input bit poke, input bit chk_lat, input string tag);
        longint sum, exp_d;
        bit     exp_s;
        int     c0, k;
        sum = bias_v;
        for (int i = 0; i < TAPS; i++) sum += longint'(ta[i]) * ty[i] + longint'(tb[i]) * tu[i];
        model(sum, exp_d, exp_s);

        bias  = bias_v[DATA_W-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
        check({tag, "_busy_accum"}, busy, 1);
        feed_taps(mode, TAPS, poke);

        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        // Start cycle is cycle 0; out_valid is seen TAPS+1 edges later, i.e. in cycle TAPS+2.
        if (chk_lat) check({tag, "_latency"}, cyc - c0, TAPS + 1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_sat"}, out_sat, exp_s);

        if (stall > 0) out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            start     = poke;
            tap_valid = 1'b1;
            tap_a     = DATA_W'($urandom);
            tap_u     = DATA_W'($urandom);
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_data"}, out_data, exp_d);
        end
        start     = 1'b0;
        tap_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_data_hold"}, out_data, exp_d);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = '0;
        tap_valid = 1'b0;
        tap_a     = '0;
        tap_b     = '0;
        tap_y     = '0;
        tap_u     = '0;
        out_ready = 1'b1;

        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tap_ready", tap_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fill_const(1, 1, 1, 1);
        eval(0, 0, 0, 1'b0, 1'b1, "unit");

        fill_const(-1, 1, 0, 0);
        eval(-5, 0, 0, 1'b0, 1'b1, "neg");

        fill_const(-128, -256, 127, 255);
        eval(127, 0, 0, 1'b0, 1'b1, "extreme");

        fill_const(1, 1, 1, 1);
        eval(0, 1, 5, 1'b0, 1'b0, "toggle_stall");

        // Abort an evaluation after four taps; nothing partial may surface.
        fill_const(1, 1, 1, 1);
        bias  = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed_taps(0, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_tap_ready", tap_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_sat", out_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        eval(0, 0, 0, 1'b0, 1'b1, "after_rst");

        fill_const(1, 1, 1, 1);
        eval(0, 0, 3, 1'b1, 1'b1, "poke");

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            eval(int'($urandom_range(0, 255)) - 128, 2, int'($urandom_range(0, 3)),
                 1'b0, 1'b0, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
